// File: rtl/adc_bufer_pack.sv
// ADC sample packer: gathers three reads per group, queues {board, line, samples}
// in a 16-entry FIFO and streams entries to memory with a ready handshake.
module adc_bufer_pack #(
   parameter int DATA_W = 12,
   parameter int LINE_W = 8
) (
   input  logic                  FRC_IN,
   input  logic                  _RES,
   input  logic [DATA_W-1:0]     ADC_DATA,
   input  logic                  _RD,
   input  logic                  WRITE_BUFER,
   input  logic [3:0]            COUNT_BOARD,
   input  logic                  CHENGE_ADRES_IN,
   input  logic                  COUNTER_F_GO,
   input  logic                  MEM_READY,
   output logic                  MEM_WE,
   output logic [LINE_W+3:0]     MEM_ADDR,
   output logic [3*DATA_W-1:0]   MEM_DATA,
   output logic [4:0]            FIFO_LEVEL,
   output logic                  OVERFLOW,
   output logic                  FRAME_ERR
);
   localparam int ADDR_W  = LINE_W + 4;
   localparam int ENTRY_W = ADDR_W + 3 * DATA_W;
   localparam int DEPTH   = 16;

   typedef enum logic {IDLE, WRITE} state_t;

   logic [3:0]              strb_s1, strb_s2, strb_s3;   // {go, chg, wb, rd}
   logic [DATA_W-1:0]       adc_s1, adc_s2;
   logic [3:0]              board_s1, board_s2;
   logic                    rd_rise, wb_rise, ch_rise, go_rise, go;

   logic [1:0]              slot;
   logic [LINE_W-1:0]       line;
   logic [2:0][DATA_W-1:0]  samples;
   logic                    push_req, push_ok, full;
   logic [ENTRY_W-1:0]      push_entry;

   logic [ENTRY_W-1:0]      fifo_mem [DEPTH];
   logic [3:0]              wr_ptr, rd_ptr;
   logic [4:0]              count;
   logic                    pop, we_nxt;
   state_t                  state, state_nxt;

   always_ff @(posedge FRC_IN) begin
      // NOTE: non-blocking assignments make each stage take the previous cycle's value, so the chain is a true pipeline.
      if (!_RES) begin
         strb_s1  <= '0;
         strb_s2  <= '0;
         strb_s3  <= '0;
         adc_s1   <= '0;
         adc_s2   <= '0;
         board_s1 <= '0;
         board_s2 <= '0;
      end else begin
         strb_s1  <= {COUNTER_F_GO, CHENGE_ADRES_IN, WRITE_BUFER, _RD};
         strb_s2  <= strb_s1;
         strb_s3  <= strb_s2;
         adc_s1   <= ADC_DATA;
         adc_s2   <= adc_s1;
         board_s1 <= COUNT_BOARD;
         board_s2 <= board_s1;
      end
   end

   assign rd_rise = strb_s2[0] & ~strb_s3[0];
   assign wb_rise = strb_s2[1] & ~strb_s3[1];
   assign ch_rise = strb_s2[2] & ~strb_s3[2];
   assign go_rise = strb_s2[3] & ~strb_s3[3];
   assign go      = strb_s2[3];

   assign full       = (count == 5'(DEPTH));
   assign push_req   = go & wb_rise & (slot == 2'd3);
   assign push_ok    = push_req & (~full | pop);
   assign push_entry = {board_s2, line, samples};

   // Group assembly: the write strobe closes a group and reopens slot 0 in the same cycle.
   always_ff @(posedge FRC_IN) begin
      if (!_RES) begin
         slot      <= '0;
         line      <= '0;
         samples   <= '0;
         OVERFLOW  <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         if (go_rise) begin
            OVERFLOW  <= 1'b0;
            FRAME_ERR <= 1'b0;
         end
         if (!go) begin
            slot <= '0;
            line <= '0;
         end else begin
            if (wb_rise) begin
               if (slot != 2'd3) FRAME_ERR <= 1'b1;
               if (rd_rise) begin
                  samples[0] <= adc_s2;
                  slot       <= 2'd1;
               end else begin
                  slot <= 2'd0;
               end
            end else if (rd_rise) begin
               if (slot == 2'd3) begin
                  FRAME_ERR <= 1'b1;
               end else begin
                  samples[slot] <= adc_s2;
                  slot          <= slot + 2'd1;
               end
            end
            if (ch_rise)       line <= '0;
            else if (push_req) line <= line + LINE_W'(1);
         end
         if (push_req && !push_ok) OVERFLOW <= 1'b1;
      end
   end

   // NOTE: the storage array has no reset; the pointers and count alone decide which entries are valid.
   always_ff @(posedge FRC_IN) begin
      if (push_ok) fifo_mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge FRC_IN) begin
      if (!_RES) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 4'd1;
         if (pop)     rd_ptr <= rd_ptr + 4'd1;
         case ({push_ok, pop})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: count <= count;
         endcase
      end
   end

   assign FIFO_LEVEL = count;

   always_comb begin
      // NOTE: every signal written here gets a default first so no path can infer a latch.
      state_nxt = state;
      pop       = 1'b0;
      we_nxt    = MEM_WE;
      case (state)
         IDLE: begin
            if (count != 5'd0) begin
               pop       = 1'b1;
               we_nxt    = 1'b1;
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            if (MEM_READY) begin
               if (count != 5'd0) begin
                  pop = 1'b1;
               end else begin
                  we_nxt    = 1'b0;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge FRC_IN) begin
      if (!_RES) begin
         state    <= IDLE;
         MEM_WE   <= 1'b0;
         MEM_ADDR <= '0;
         MEM_DATA <= '0;
      end else begin
         state  <= state_nxt;
         MEM_WE <= we_nxt;
         if (pop) {MEM_ADDR, MEM_DATA} <= fifo_mem[rd_ptr];
      end
   end

endmodule
